// File: rtl/pipe_share_pkg.sv
// Shared helpers for pipe_share_arbiter: index width, round-robin pick and one-hot decode.
// Vectors are passed at a fixed maximum width; callers zero-extend and truncate with casts.
package pipe_share_pkg;

    localparam int unsigned MAX_REQ  = 64;
    localparam int unsigned MAX_ID_W = 6;

    function automatic int unsigned id_width(input int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | MAX_ID_W'(i);
        end
        return idx;
    endfunction

    // Scan from ptr+1 upward, wrapping at n_req; first valid requester wins.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input int unsigned n_req,
                                                   input int unsigned ptr);
        logic [MAX_REQ-1:0]  grant;
        logic [MAX_ID_W-1:0] sel;
        int unsigned         idx;
        grant = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n_req && grant == '0) begin
                idx = ptr + k;
                if (idx >= n_req) idx = idx - n_req;
                sel = MAX_ID_W'(idx);
                if (valid[sel]) grant[sel] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/pipe_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick from a registered pointer that
// moves to the granted requester on every transfer.
module rr_arbiter
    import pipe_share_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                i_hold,
    input  logic [N_REQ-1:0]    i_valid,
    output logic [N_REQ-1:0]    o_grant,
    output logic [ID_WIDTH-1:0] o_grant_idx
);

    logic [ID_WIDTH-1:0] r_ptr;
    logic [N_REQ-1:0]    w_pick;

    always_comb begin
        w_pick = N_REQ'(rr_pick(MAX_REQ'(i_valid), N_REQ, 32'(r_ptr)));
    end

    // Grant only where valid is high, so any set grant bit is a transfer.
    assign o_grant     = i_hold ? '0 : w_pick;
    assign o_grant_idx = ID_WIDTH'(onehot_to_idx(MAX_REQ'(o_grant)));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_ptr <= ID_WIDTH'(N_REQ - 1);
        end else if (|o_grant) begin
            r_ptr <= o_grant_idx;
        end
    end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Shares one fixed-latency pipelined unit among N_REQ requesters; a tag delay line
// carries each operation's requester ID alongside the unit and routes results back.
module pipe_share_arbiter
    import pipe_share_pkg::*;
#(
    parameter  int unsigned N_REQ      = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned RES_WIDTH  = 32,
    parameter  int unsigned LATENCY    = 6,
    localparam int unsigned ID_WIDTH   = id_width(N_REQ)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        hold_in,
    input  logic [N_REQ-1:0]            req_valid_in,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_in,
    output logic [N_REQ-1:0]            req_ready_out,
    output logic                        unit_valid_out,
    output logic [DATA_WIDTH-1:0]       unit_data_out,
    input  logic [RES_WIDTH-1:0]        unit_result_in,
    output logic [N_REQ-1:0]            res_valid_out,
    output logic [RES_WIDTH-1:0]        res_data_out,
    output logic [ID_WIDTH-1:0]         res_id_out,
    output logic                        busy_out
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 2) + 1;

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } tag_t;

    logic [N_REQ-1:0]      w_grant;
    logic [ID_WIDTH-1:0]   w_idx;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_req_data [N_REQ];
    tag_t                  w_last;
    logic [CNT_W-1:0]      w_cnt_next;

    // Slot 0 is the issue register, so LATENCY+1 stages line up with unit_result_in.
    tag_t                  r_tag [LATENCY+1];
    logic [DATA_WIDTH-1:0] r_unit_data;
    logic [N_REQ-1:0]      r_res_valid;
    logic [RES_WIDTH-1:0]  r_res_data;
    logic [ID_WIDTH-1:0]   r_res_id;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;

    rr_arbiter #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_hold      (hold_in),
        .i_valid     (req_valid_in),
        .o_grant     (w_grant),
        .o_grant_idx (w_idx)
    );

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_req_data[g] = req_data_in[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_xfer = |w_grant;
    assign w_last = r_tag[LATENCY];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned k = 0; k <= LATENCY; k++) r_tag[k] <= '0;
            r_unit_data <= '0;
        end else begin
            r_tag[0] <= '{valid: w_xfer, id: w_idx};
            for (int unsigned k = 1; k <= LATENCY; k++) r_tag[k] <= r_tag[k-1];
            if (w_xfer) r_unit_data <= w_req_data[w_idx];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_res_valid <= '0;
            r_res_data  <= '0;
            r_res_id    <= '0;
        end else if (w_last.valid) begin
            r_res_valid <= N_REQ'(1) << w_last.id;
            r_res_data  <= unit_result_in;
            r_res_id    <= w_last.id;
        end else begin
            r_res_valid <= '0;
        end
    end

    // Retire when the return stage commits, so a full pipe holds LATENCY+1 in flight;
    // busy stays up through the cycle the last result is presented.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_xfer && !w_last.valid) w_cnt_next = r_cnt + CNT_W'(1);
        else if (!w_xfer && w_last.valid) w_cnt_next = r_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_busy <= (w_cnt_next != '0) || w_last.valid;
        end
    end

    assign req_ready_out  = w_grant;
    assign unit_valid_out = r_tag[0].valid;
    assign unit_data_out  = r_unit_data;
    assign res_valid_out  = r_res_valid;
    assign res_data_out   = r_res_data;
    assign res_id_out     = r_res_id;
    assign busy_out       = r_busy;

endmodule
